// File: rtl/edac_crc_seq_decoder.sv
// Bit-serial CRC-4 read-path decoder: two nibble codewords per 32-bit word.
// Syndrome, LFSR position search, single-bit correction, fixed latency.
module edac_crc_seq_decoder #(
  parameter logic [31:0] ERROR_CODE = 32'hFFFF_FFFF,
  parameter logic [3:0]  CRC        = 4'h9
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] DIN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] DOUT,
  output logic [1:0]  corrected,
  output logic        uncorrectable
);

  typedef enum logic [1:0] {
    IDLE,
    SYND,
    SEARCH,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cw_lo_q, cw_lo_d;
  logic [15:0] cw_hi_q, cw_hi_d;
  logic [3:0]  s_lo_q, s_lo_d;
  logic [3:0]  s_hi_q, s_hi_d;
  logic [3:0]  ref_q, ref_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  pos_lo_q, pos_lo_d;
  logic [2:0]  pos_hi_q, pos_hi_d;
  logic        hit_lo_q, hit_lo_d;
  logic        hit_hi_q, hit_hi_d;
  logic        ov_q, ov_d;
  logic [31:0] dout_q, dout_d;
  logic [1:0]  corr_q, corr_d;
  logic        unc_q, unc_d;

  logic [7:0]  lo_b, hi_b;
  logic [2:0]  idx;
  logic [5:0]  fix_lo, fix_hi;

  function automatic logic [3:0] lfsr(
    input logic [3:0] s,
    input logic       b
  );
    return {s[2:0], b} ^ (s[3] ? CRC : 4'h0);
  endfunction

  // Returns {fail, corrected, data}.
  function automatic logic [5:0] fix(
    input logic [15:0] cw,
    input logic [3:0]  s,
    input logic        hit,
    input logic [2:0]  pos
  );
    logic [7:0] f;
    logic       fl;
    logic       c;
    f  = cw[7:0];
    fl = |cw[15:8];
    c  = 1'b0;
    if (s != 4'h0) begin
      if (hit) begin
        f = f ^ (8'h01 << pos);
        c = 1'b1;
      end else begin
        fl = 1'b1;
      end
    end
    return {fl, c, f[7:4]};
  endfunction

  assign lo_b   = cw_lo_q[7:0];
  assign hi_b   = cw_hi_q[7:0];
  assign idx    = 3'd7 - cnt_q;
  assign fix_lo = fix(cw_lo_q, s_lo_q, hit_lo_q, pos_lo_q);
  assign fix_hi = fix(cw_hi_q, s_hi_q, hit_hi_q, pos_hi_q);

  always_comb begin
    state_d  = state_q;
    cw_lo_d  = cw_lo_q;
    cw_hi_d  = cw_hi_q;
    s_lo_d   = s_lo_q;
    s_hi_d   = s_hi_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    pos_lo_d = pos_lo_q;
    pos_hi_d = pos_hi_q;
    hit_lo_d = hit_lo_q;
    hit_hi_d = hit_hi_q;
    ov_d     = ov_q;
    dout_d   = dout_q;
    corr_d   = corr_q;
    unc_d    = unc_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            cw_lo_d = DIN[15:0];
            cw_hi_d = DIN[31:16];
            s_lo_d  = 4'h0;
            s_hi_d  = 4'h0;
            cnt_d   = 3'd0;
            state_d = SYND;
          end
        end
        SYND: begin
          s_lo_d = lfsr(s_lo_q, lo_b[idx]);
          s_hi_d = lfsr(s_hi_q, hi_b[idx]);
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ref_d    = 4'b0001;
            hit_lo_d = 1'b0;
            hit_hi_d = 1'b0;
            pos_lo_d = 3'd0;
            pos_hi_d = 3'd0;
            state_d  = SEARCH;
          end
        end
        SEARCH: begin
          // First match wins, so the lowest error position is kept.
          if (s_lo_q != 4'h0 && !hit_lo_q && ref_q == s_lo_q) begin
            hit_lo_d = 1'b1;
            pos_lo_d = cnt_q;
          end
          if (s_hi_q != 4'h0 && !hit_hi_q && ref_q == s_hi_q) begin
            hit_hi_d = 1'b1;
            pos_hi_d = cnt_q;
          end
          ref_d = lfsr(ref_q, 1'b0);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (!ov_q) begin
            ov_d = 1'b1;
            if (fix_lo[5] || fix_hi[5]) begin
              dout_d = ERROR_CODE;
              corr_d = 2'b00;
              unc_d  = 1'b1;
            end else begin
              dout_d = {24'h0, fix_hi[3:0], fix_lo[3:0]};
              corr_d = {fix_hi[4], fix_lo[4]};
              unc_d  = 1'b0;
            end
          end else if (out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cw_lo_q  <= '0;
      cw_hi_q  <= '0;
      s_lo_q   <= '0;
      s_hi_q   <= '0;
      ref_q    <= 4'b0001;
      cnt_q    <= '0;
      pos_lo_q <= '0;
      pos_hi_q <= '0;
      hit_lo_q <= 1'b0;
      hit_hi_q <= 1'b0;
      ov_q     <= 1'b0;
      dout_q   <= '0;
      corr_q   <= '0;
      unc_q    <= 1'b0;
    end else begin
      cw_lo_q  <= cw_lo_d;
      cw_hi_q  <= cw_hi_d;
      s_lo_q   <= s_lo_d;
      s_hi_q   <= s_hi_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      pos_lo_q <= pos_lo_d;
      pos_hi_q <= pos_hi_d;
      hit_lo_q <= hit_lo_d;
      hit_hi_q <= hit_hi_d;
      ov_q     <= ov_d;
      dout_q   <= dout_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = ov_q;
  assign DOUT          = dout_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;

endmodule

// File: tb/tb_edac_crc_seq_decoder.sv
// Directed bench for edac_crc_seq_decoder.
// Hand-computed vectors for g(x)=x^4+x^3+1.
module tb_edac_crc_seq_decoder;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] DIN = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] DOUT;
  logic [1:0]  corrected;
  logic        uncorrectable;

  int tests = 0;
  int fails = 0;

  edac_crc_seq_decoder dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .en            (en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .DIN           (DIN),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .DOUT          (DOUT),
    .corrected     (corrected),
    .uncorrectable (uncorrectable)
  );

  always #5 CLK = ~CLK;

  task automatic accept(input logic [31:0] d);
    @(negedge CLK);
    DIN = d;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    DIN = 32'hDEAD_BEEF;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || DOUT !== 32'h0) begin
      fails++;
      $display("FAIL reset_out got v=%b d=%h want v=0 d=0",
               out_valid, DOUT);
    end
    tests++;
    if (corrected !== 2'b00 || uncorrectable !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got c=%b u=%b want 00/0",
               corrected, uncorrectable);
    end
  endtask

  task automatic test_vec(input string nm, input logic [31:0] din,
                          input logic [31:0] exp_d,
                          input logic [1:0] exp_c,
                          input logic exp_u);
    int lat;
    accept(din);
    wait_out(lat);
    tests++;
    if (lat !== 17) begin
      fails++;
      $display("FAIL %s_latency got %0d want 17", nm, lat);
    end
    tests++;
    if (DOUT !== exp_d || corrected !== exp_c ||
        uncorrectable !== exp_u) begin
      fails++;
      $display("FAIL %s got d=%h c=%b u=%b want d=%h c=%b u=%b",
               nm, DOUT, corrected, uncorrectable,
               exp_d, exp_c, exp_u);
    end
    ack();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ack got v=%b r=%b want v=0 r=1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept(32'h00AC_0052);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      DIN = 32'h01AC_0053;
      @(posedge CLK);
      #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          DOUT !== 32'h0000_00A5 || corrected !== 2'b01 ||
          uncorrectable !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d got v=%b r=%b d=%h c=%b want 1/0/a5/01",
                 i, out_valid, in_ready, DOUT, corrected);
      end
    end
    in_valid = 1'b0;
    ack();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_ack got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_en_stall();
    int lat;
    accept(32'h002C_0056);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      if (lat == 3) en = 1'b0;
      if (lat == 6) en = 1'b1;
      @(posedge CLK);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 20) begin
      fails++;
      $display("FAIL en_latency got %0d want 20", lat);
    end
    tests++;
    if (DOUT !== 32'h0000_00A5 || corrected !== 2'b10) begin
      fails++;
      $display("FAIL en_data got d=%h c=%b want 000000a5/10",
               DOUT, corrected);
    end
    @(negedge CLK);
    en = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL en_hs_blocked got v=%b r=%b want v=1 r=0",
               out_valid, in_ready);
    end
    en = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL en_hs got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    accept(32'h01AC_0053);
    repeat (12) @(posedge CLK);
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        DOUT !== 32'h0 || uncorrectable !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got r=%b v=%b d=%h u=%b want 1/0/0/0",
               in_ready, out_valid, DOUT, uncorrectable);
    end
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rst_no_output got %0d want 0", seen);
    end
    test_vec("rst_next", 32'h002B_00AC, 32'h0000_002A, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    accept(32'h00AC_0056);
    wait_out(lat);
    @(negedge CLK);
    in_valid = 1'b1;
    DIN = 32'h00AC_000B;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got r=%b v=%b want r=1 v=0",
               in_ready, out_valid);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    DIN = 32'hDEAD_BEEF;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept got r=%b want 0", in_ready);
    end
    wait_out(lat);
    tests++;
    if (lat !== 17 || DOUT !== 32'h0000_00A2 || corrected !== 2'b01) begin
      fails++;
      $display("FAIL b2b got lat=%0d d=%h c=%b want 17/000000a2/01",
               lat, DOUT, corrected);
    end
    ack();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge CLK);
    reset_n = 1'b1;
    test_vec("clean", 32'h00AC_0056, 32'h0000_00A5, 2'b00, 1'b0);
    test_vec("lo_chk", 32'h00AC_0052, 32'h0000_00A5, 2'b01, 1'b0);
    test_vec("hi_data", 32'h002C_0056, 32'h0000_00A5, 2'b10, 1'b0);
    test_vec("lo_double", 32'h00AC_0053, 32'hFFFF_FFFF, 2'b00, 1'b1);
    test_vec("pad", 32'h01AC_0056, 32'hFFFF_FFFF, 2'b00, 1'b1);
    test_vec("both", 32'h002C_000B, 32'h0000_00A2, 2'b11, 1'b0);
    test_backpressure();
    test_en_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edac_crc_seq_decoder.md
Name: edac_crc_seq_decoder

Overview:
- Multi-cycle read-path decoder for 32-bit memory words holding two CRC-4 protected nibble codewords.
- Low codeword is DIN[15:0]; high codeword is DIN[31:16].
- Computes syndromes bit-serially, locates single-bit errors by a fixed-length LFSR search, corrects them and returns the 8-bit payload.
- Reports ERROR_CODE when either half cannot be corrected. Sits between the memory read port and the core load path, with valid/ready handshakes on both sides.

Parameters:
- ERROR_CODE, 32'hFFFFFFFF, DOUT value when either half is uncorrectable.
- CRC, 4'h9, generator low bits; x^4 is implicit, so the default is g(x)=x^4+x^3+1.

Ports:
- CLK  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low, all state and outputs hold.
- in_valid  in  1  DIN carries a word to decode.
- in_ready  out  1  high only in IDLE.
- DIN  in  32  two 16-bit codewords.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- DOUT  out  32  {24'b0, data_hi[3:0], data_lo[3:0]}, or ERROR_CODE.
- corrected  out  2  bit0 = low half corrected, bit1 = high half corrected.
- uncorrectable  out  1  either half failed.

Behaviour:
- Codeword format: bit i is the coefficient of x^i.
  - cw[7:4] = data.
  - cw[3:0] = (data·x^4) mod g.
  - cw[15:8] must be zero.
- Reset: state = IDLE; in_ready=1, out_valid=0, DOUT=0, corrected=0, uncorrectable=0; counters cleared. Reset asserted mid-operation aborts the word; no output is produced for it.
- en=0: every register holds, including during handshakes. A handshake only completes on an edge with en=1.
- FSM states: IDLE, SYND, SEARCH, DONE.
- IDLE: on in_valid && en, latch DIN, clear both syndromes, count=0, go to SYND.
- SYND, 8 cycles: both halves run in parallel, MSB first from cw[7] down to cw[0].
  - Update per bit: s_next = {s[2:0],bit} ^ (s[3] ? CRC : 0).
  - After the 8th cycle, go to SEARCH.
- SEARCH, exactly 8 cycles regardless of outcome (constant latency).
  - ref starts at 4'b0001, which represents position 0.
  - Each cycle, compare ref to each nonzero syndrome. On the first match, record pos = count.
  - Update ref = {ref[2:0],1'b0} ^ (ref[3] ? CRC : 0). Increment count.
  - The lowest matching position wins.
  - After 8 cycles, go to DONE.
- DONE entry (single registered update):
  - Per half, if syndrome==0: data = cw[7:4].
  - Else if matched: flip bit pos, then take [7:4]; set the corrected bit. A flip in [3:0] still sets corrected, with data unchanged.
  - Else: the half fails.
  - Either cw[15:8] != 0 also marks that half failed.
  - If any half failed: DOUT=ERROR_CODE, uncorrectable=1, corrected=0.
  - out_valid=1.
- Latency: acceptance edge E; out_valid rises after edge E+17 (8 SYND + 8 SEARCH + 1 DONE load), with en continuously high.
- DONE holds DOUT and flags stable while out_ready=0. On out_valid && out_ready && en, go to IDLE. out_valid falls and in_ready rises on the same edge.
- A new word is accepted no earlier than the following edge. in_valid while busy is ignored; DIN is not sampled.
- Double errors whose syndrome aliases a single-error syndrome are miscorrected. This is a known limit of the code and is not flagged.
- Default-poly reference syndromes, positions 0..7: 1, 2, 4, 8, 9, B, F, 7.

Test Plan:
- Clean word: reset, DIN=32'h00AC_0056, in_valid pulse → out_valid 17 cycles after acceptance, DOUT=32'h0000_00A5, corrected=00, uncorrectable=0.
- Low single error in check bit: DIN=32'h00AC_0052 (bit 2 flipped) → DOUT=32'h0000_00A5, corrected=01.
- High single error in data bit: DIN=32'h002C_0056 (bit 7 flipped) → DOUT=32'h0000_00A5, corrected=10.
- Low double error: DIN=32'h00AC_0053 (syndrome 4'h5, no match) → DOUT=32'hFFFF_FFFF, uncorrectable=1, corrected=00.
- Nonzero pad: DIN=32'h01AC_0056 → DOUT=32'hFFFF_FFFF, uncorrectable=1.
- Control scenario, in three parts:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
  - Drop en for 3 cycles mid-SYND → latency extends by exactly 3.
  - Assert reset_n=0 mid-SEARCH → immediately in_ready=1, out_valid=0, DOUT=0; the next word decodes correctly.
